// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets and sync polarity codes
// Purpose: per-axis timing record plus standard mode presets shared by the
//          raster engine and its users.
// Ports:   none (package).
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  localparam axis_timing_t VGA_640X480_60_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam axis_timing_t VGA_640X480_60_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam axis_timing_t VGA_800X600_72_H = '{active: 800, fp: 56, sync: 120, bp: 64};
  localparam axis_timing_t VGA_800X600_72_V = '{active: 600, fp: 37, sync: 6,   bp: 23};

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis counter with region decode
// Purpose: counts 0..TOTAL-1 on each ce and decodes the active and sync
//          regions (order: active, front porch, sync, back porch).
// Ports:   clk, rst_n (async active-low), ce (advance enable);
//          cnt (current position), active (cnt in active region),
//          active_next (position after the next ce is active),
//          sync (cnt in sync region, active-high), wrap (cnt is TOTAL-1).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter  int ACTIVE = 640,
  parameter  int FP     = 16,
  parameter  int SYNC   = 96,
  parameter  int BP     = 48,
  localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int CNT_W  = $clog2(TOTAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             active_next,
  output logic             sync,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ce) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  assign wrap   = (cnt == LAST);
  assign active = (cnt < CNT_W'(ACTIVE));
  assign sync   = (cnt >= SYNC_START) && (cnt < SYNC_END);
  // Next position is 0 on wrap (always active), otherwise cnt+1 < ACTIVE.
  assign active_next = wrap || (cnt < CNT_W'(ACTIVE - 1));

endmodule

// File: rtl/vga_timing_engine.sv
// rtl/vga_timing_engine.sv - parametrised VGA raster engine
// Purpose: pixel-rate strobe, H/V raster counters, pixel request with
//          coordinates, and a one-pixel output stage that blanks colour
//          outside the active area and aligns syncs with colour.
// Ports:   clk, rst_n (async active-low); in_r/in_g/in_b (requested pixel
//          colour); px_req, px_x, px_y (current pixel request/position);
//          out_r/out_g/out_b (blanked colour); h_sync, v_sync (polarity per
//          SYNC_POL); frame_start (1-clk pulse on wrap to (0,0)).
module vga_timing_engine
  import vga_pkg::*;
#(
  parameter  int COLOR_W  = 1,
  parameter  int CLK_DIV  = 4,
  parameter  int H_ACTIVE = VGA_640X480_60_H.active,
  parameter  int H_FP     = VGA_640X480_60_H.fp,
  parameter  int H_SYNC   = VGA_640X480_60_H.sync,
  parameter  int H_BP     = VGA_640X480_60_H.bp,
  parameter  int V_ACTIVE = VGA_640X480_60_V.active,
  parameter  int V_FP     = VGA_640X480_60_V.fp,
  parameter  int V_SYNC   = VGA_640X480_60_V.sync,
  parameter  int V_BP     = VGA_640X480_60_V.bp,
  parameter  bit SYNC_POL = SYNC_ACTIVE_LOW,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W      = $clog2(H_TOTAL),
  localparam int Y_W      = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] in_r,
  input  logic [COLOR_W-1:0] in_g,
  input  logic [COLOR_W-1:0] in_b,
  output logic               px_req,
  output logic [X_W-1:0]     px_x,
  output logic [Y_W-1:0]     px_y,
  output logic [COLOR_W-1:0] out_r,
  output logic [COLOR_W-1:0] out_g,
  output logic [COLOR_W-1:0] out_b,
  output logic               h_sync,
  output logic               v_sync,
  output logic               frame_start
);

  if (COLOR_W < 1 || CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_engine: COLOR_W, CLK_DIV and every timing interval must be >= 1");
  end

  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic             IDLE_SYNC = !SYNC_POL;

  logic [DIV_W-1:0] div_cnt;
  logic             pix_ce;
  logic [X_W-1:0]   h_cnt;
  logic [Y_W-1:0]   v_cnt;
  logic             h_active, h_active_next, h_in_sync, h_wrap;
  logic             v_active, v_active_next, v_in_sync, v_wrap;
  logic             px_active;

  // Pixel strobe; with CLK_DIV = 1 DIV_LAST is 0 so pix_ce is constantly high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign pix_ce = (div_cnt == DIV_LAST);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .ce(pix_ce),
    .cnt(h_cnt), .active(h_active), .active_next(h_active_next),
    .sync(h_in_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .ce(pix_ce && h_wrap),
    .cnt(v_cnt), .active(v_active), .active_next(v_active_next),
    .sync(v_in_sync), .wrap(v_wrap)
  );

  assign px_x      = h_cnt;
  assign px_y      = v_cnt;
  assign px_active = h_active && v_active;

  // px_req is loaded with the activity of the position the counters hold
  // after this edge, so it stays in step with px_x/px_y yet still reads 0
  // while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_req <= 1'b0;
    end else if (pix_ce) begin
      px_req <= h_active_next && (h_wrap ? v_active_next : v_active);
    end else begin
      px_req <= px_active;
    end
  end

  // Output stage: one pixel behind the counters; colour and syncs of the
  // pixel that is ending are captured together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_g       <= '0;
      out_b       <= '0;
      h_sync      <= IDLE_SYNC;
      v_sync      <= IDLE_SYNC;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && h_wrap && v_wrap;
      if (pix_ce) begin
        out_r  <= px_active ? in_r : '0;
        out_g  <= px_active ? in_g : '0;
        out_b  <= px_active ? in_b : '0;
        h_sync <= h_in_sync ? SYNC_POL : IDLE_SYNC;
        v_sync <= v_in_sync ? SYNC_POL : IDLE_SYNC;
      end
    end
  end

endmodule
